// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port memory arbiter: grant encoding and
// starvation counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_INS  = 2'd1,
      GNT_DRD  = 2'd2,
      GNT_DWR  = 2'd3
   } gnt_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant pick: write > data read > fetch, except that a fetch
// that has hit its starvation limit wins outright.
import mem_arb_pkg::*;

module arb_pick (
   input  logic ins_req,
   input  logic dat_rd_req,
   input  logic dat_wr_req,
   input  logic starve_hit,
   output gnt_t gnt
);

   always_comb begin
      gnt = GNT_NONE;
      if (starve_hit && ins_req)
         gnt = GNT_INS;
      else if (dat_wr_req)
         gnt = GNT_DWR;
      else if (dat_rd_req)
         gnt = GNT_DRD;
      else if (ins_req)
         gnt = GNT_INS;
   end

endmodule

// File: rtl/mem_arbiter16.sv
// Shares one registered-read memory between the fetch port and the data
// port, one access per cycle, with a starvation guard on fetch.
import mem_arb_pkg::*;

module mem_arbiter16 #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] ins_rd_addr,
   input  logic          ins_rd_req,
   output logic [DW-1:0] ins_rd_data,
   output logic          ins_rd_rdy,
   input  logic [AW-1:0] dat_rw_addr,
   input  logic [DW-1:0] dat_wr_data,
   input  logic          dat_rd_req,
   input  logic          dat_wr_req,
   output logic [DW-1:0] dat_rd_data,
   output logic          dat_rd_rdy,
   output logic          dat_wr_rdy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   gnt_t                gnt;
   gnt_t                gnt_q;
   logic [STARVE_W-1:0] starve_q;
   logic [DW-1:0]       ins_hold;
   logic [DW-1:0]       dat_hold;
   logic                starve_hit;

   assign starve_hit = (starve_q == STARVE_MAX);

   arb_pick u_pick (
      .ins_req    (ins_rd_req),
      .dat_rd_req (dat_rd_req),
      .dat_wr_req (dat_wr_req),
      .starve_hit (starve_hit),
      .gnt        (gnt)
   );

   // Enables are gated by reset so nothing reaches the memory while held.
   always_comb begin
      mem_addr  = dat_rw_addr;
      mem_wdata = dat_wr_data;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (gnt)
         GNT_INS: begin
            mem_addr = ins_rd_addr;
            mem_re   = reset_n;
         end
         GNT_DRD: mem_re = reset_n;
         GNT_DWR: mem_we = reset_n;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q    <= GNT_NONE;
         starve_q <= '0;
         ins_hold <= '0;
         dat_hold <= '0;
      end else begin
         gnt_q <= gnt;
         if (gnt_q == GNT_INS)
            ins_hold <= mem_rdata;
         if (gnt_q == GNT_DRD)
            dat_hold <= mem_rdata;
         if (ins_rd_req && (gnt != GNT_INS)) begin
            if (!starve_hit)
               starve_q <= starve_q + 4'd1;
         end else begin
            starve_q <= '0;
         end
      end
   end

   assign ins_rd_rdy  = (gnt_q == GNT_INS);
   assign dat_rd_rdy  = (gnt_q == GNT_DRD);
   assign dat_wr_rdy  = (gnt_q == GNT_DWR);
   assign ins_rd_data = ins_rd_rdy ? mem_rdata : ins_hold;
   assign dat_rd_data = dat_rd_rdy ? mem_rdata : dat_hold;

endmodule

// File: tb/tb_mem_arbiter16.sv
// Scoreboard bench for mem_arbiter16: directed stimulus pushes expected
// ready events, a negedge monitor pops and compares them.
import mem_arb_pkg::*;

module tb_mem_arbiter16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] ins_rd_addr = '0;
   logic        ins_rd_req = 1'b0;
   logic [15:0] ins_rd_data;
   logic        ins_rd_rdy;
   logic [15:0] dat_rw_addr = '0;
   logic [15:0] dat_wr_data = '0;
   logic        dat_rd_req = 1'b0;
   logic        dat_wr_req = 1'b0;
   logic [15:0] dat_rd_data;
   logic        dat_rd_rdy;
   logic        dat_wr_rdy;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_rdata = '0;

   mem_arbiter16 #(.AW(16), .DW(16), .STARVE_LIMIT(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ins_rd_addr (ins_rd_addr),
      .ins_rd_req  (ins_rd_req),
      .ins_rd_data (ins_rd_data),
      .ins_rd_rdy  (ins_rd_rdy),
      .dat_rw_addr (dat_rw_addr),
      .dat_wr_data (dat_wr_data),
      .dat_rd_req  (dat_rd_req),
      .dat_wr_req  (dat_wr_req),
      .dat_rd_data (dat_rd_data),
      .dat_rd_rdy  (dat_rd_rdy),
      .dat_wr_rdy  (dat_wr_rdy),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: unwritten locations hold addr ^ A5A5 except two fixed words.
   logic [15:0] wmem [int];

   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a == 16'h0100) return 16'h1234;
      if (a == 16'h0200) return 16'h5678;
      return a ^ 16'hA5A5;
   endfunction

   always @(posedge clk) begin
      if (mem_re)
         mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : init_val(mem_addr);
      if (mem_we)
         wmem[int'(mem_addr)] = mem_wdata;
   end

   typedef struct {
      gnt_t        kind;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input gnt_t k, input logic [15:0] d);
      exp_t e;
      e.kind = k;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   logic [15:0] last_ins = '0;
   logic [15:0] last_dat = '0;

   always @(negedge clk) begin
      logic [2:0] r;
      gnt_t       act;
      exp_t       e;
      r = {dat_wr_rdy, dat_rd_rdy, ins_rd_rdy};
      if (!reset_n) begin
         chk("rdy_in_reset", 32'(r), 32'd0);
         chk("data_in_reset", {ins_rd_data, dat_rd_data}, 32'd0);
         last_ins = '0;
         last_dat = '0;
      end else begin
         if (r != 3'b000) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rdy: got rdy %b, expected none (cycle %0d)", r, cyc);
            end else begin
               e = exp_q.pop_front();
               case (r)
                  3'b001:  act = GNT_INS;
                  3'b010:  act = GNT_DRD;
                  3'b100:  act = GNT_DWR;
                  default: act = GNT_NONE;
               endcase
               chk("rdy_kind", 32'(act), 32'(e.kind));
               chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
               if (e.kind == GNT_INS && ins_rd_rdy) begin
                  chk("ins_rd_data", 32'(ins_rd_data), 32'(e.data));
                  last_ins = e.data;
               end
               if (e.kind == GNT_DRD && dat_rd_rdy) begin
                  chk("dat_rd_data", 32'(dat_rd_data), 32'(e.data));
                  last_dat = e.data;
               end
            end
         end
         if (!ins_rd_rdy) chk("ins_data_stable", 32'(ins_rd_data), 32'(last_ins));
         if (!dat_rd_rdy) chk("dat_data_stable", 32'(dat_rd_data), 32'(last_dat));
      end
   end

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_gnt_q", 32'(dut.gnt_q), 32'(GNT_NONE));
      chk("rst_starve_q", 32'(dut.starve_q), 32'd0);
      chk("rst_mem_en", {30'd0, mem_re, mem_we}, 32'd0);
      chk("rst_rdy", {29'd0, dat_wr_rdy, dat_rd_rdy, ins_rd_rdy}, 32'd0);
      reset_n = 1'b1;

      // Instruction stream from the first cycle after release
      ins_rd_req = 1'b1;
      for (int a = 0; a < 4; a++) begin
         ins_rd_addr = 16'(a);
         push(GNT_INS, 16'(a) ^ 16'hA5A5);
         step();
      end
      ins_rd_req = 1'b0;
      step();

      // Write then read back
      dat_rw_addr = 16'h0010;
      dat_wr_data = 16'hBEEF;
      dat_wr_req  = 1'b1;
      push(GNT_DWR, 16'h0000);
      step();
      dat_wr_req = 1'b0;
      dat_rd_req = 1'b1;
      push(GNT_DRD, 16'hBEEF);
      step();
      dat_rd_req = 1'b0;
      step();

      // Contention R + I: fetch wins every fourth cycle, address sampled at issue
      dat_rw_addr = 16'h0020;
      dat_rd_req  = 1'b1;
      ins_rd_req  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ins_rd_addr = 16'(8 + k);
         if (k % 4 == 3) push(GNT_INS, 16'(8 + k) ^ 16'hA5A5);
         else            push(GNT_DRD, 16'hA585);
         step();
      end
      dat_rd_req = 1'b0;
      ins_rd_req = 1'b0;
      step();

      // Fetch data held across a data read
      ins_rd_addr = 16'h0100;
      ins_rd_req  = 1'b1;
      push(GNT_INS, 16'h1234);
      step();
      ins_rd_req  = 1'b0;
      dat_rw_addr = 16'h0200;
      dat_rd_req  = 1'b1;
      push(GNT_DRD, 16'h5678);
      step();
      dat_rd_req = 1'b0;
      step();
      step();
      chk("ins_hold_after_drd", 32'(ins_rd_data), 32'h1234);

      // Simultaneous R and W: write first, read address changes while waiting
      dat_rw_addr = 16'h0030;
      dat_wr_data = 16'hCAFE;
      dat_wr_req  = 1'b1;
      dat_rd_req  = 1'b1;
      push(GNT_DWR, 16'h0000);
      step();
      dat_wr_req  = 1'b0;
      dat_rw_addr = 16'h0040;
      push(GNT_DRD, 16'hA5E5);
      step();
      dat_rw_addr = 16'h0030;
      push(GNT_DRD, 16'hCAFE);
      step();
      dat_rd_req = 1'b0;
      step();

      // Reset in the issue cycle of a fetch; starve_q is nonzero going in.
      // The preceding write's ready is also cut short by reset, so none expected.
      dat_rw_addr = 16'h0050;
      dat_wr_data = 16'h1111;
      dat_wr_req  = 1'b1;
      ins_rd_addr = 16'h0007;
      ins_rd_req  = 1'b1;
      step();
      chk("starve_before_rst", 32'(dut.starve_q), 32'd1);
      dat_wr_req = 1'b0;
      reset_n    = 1'b0;
      #1;
      chk("rst_mem_re_forced", {30'd0, mem_re, mem_we}, 32'd0);
      chk("rst_starve_clear", 32'(dut.starve_q), 32'd0);
      step();
      chk("rst_no_ins_rdy", 32'(ins_rd_rdy), 32'd0);
      reset_n = 1'b1;
      push(GNT_INS, 16'hA5A2);
      step();
      ins_rd_req = 1'b0;
      repeat (3) step();

      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_rdy: got no rdy, expected kind %0d at cycle %0d", e.kind, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
